// File: rtl/num_display_ctrl.sv
// Three-digit decimal readout controller: converts a clamped binary value to BCD once per frame
// (serial double-dabble) and selects the digit/glyph box to draw for the current pixel column.
module num_display_ctrl #(
    parameter logic [9:0] BASE_X = 10'd16,
    parameter logic [9:0] BASE_Y = 10'd16,
    parameter logic [9:0] PITCH  = 10'd8
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic       frame,
    input  logic [9:0] value,
    input  logic [9:0] sx,
    input  logic [9:0] sy,
    output logic [3:0] digit,
    output logic [9:0] char_x,
    output logic [9:0] char_y,
    output logic       blank,
    output logic       busy,
    output logic       sat
);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    localparam logic [9:0] MAX_VAL = 10'd999;
    localparam logic [9:0] X_TENS  = BASE_X + PITCH;
    localparam logic [9:0] X_UNITS = BASE_X + PITCH + PITCH;

    state_t      state_q, state_d;
    logic [9:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [11:0] bcd_adj;
    logic [3:0]  cnt_q, cnt_d;
    logic        clamp_q, clamp_d;
    logic        sat_q, sat_d;
    logic [3:0]  d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
    logic [1:0]  idx;
    logic        sy_unused;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            clamp_q <= 1'b0;
            sat_q   <= 1'b0;
            d2_q    <= '0;
            d1_q    <= '0;
            d0_q    <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            clamp_q <= clamp_d;
            sat_q   <= sat_d;
            d2_q    <= d2_d;
            d1_q    <= d1_d;
            d0_q    <= d0_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        clamp_d = clamp_q;
        sat_d   = sat_q;
        d2_d    = d2_q;
        d1_d    = d1_q;
        d0_d    = d0_q;
        bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
        case (state_q)
            IDLE: begin
                if (frame) begin
                    bin_d   = (value > MAX_VAL) ? MAX_VAL : value;
                    bcd_d   = '0;
                    cnt_d   = 4'd10;
                    clamp_d = (value > MAX_VAL);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                bcd_d = {bcd_adj[10:0], bin_q[9]};
                bin_d = {bin_q[8:0], 1'b0};
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) state_d = COMMIT;
            end
            COMMIT: begin
                d2_d    = bcd_q[11:8];
                d1_d    = bcd_q[7:4];
                d0_d    = bcd_q[3:0];
                sat_d   = clamp_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Column decode is purely combinational so glyph selection tracks sx with no delay.
    always_comb begin
        idx = 2'd0;
        if (sx >= X_UNITS)     idx = 2'd2;
        else if (sx >= X_TENS) idx = 2'd1;
    end

    always_comb begin
        digit  = d2_q;
        char_x = BASE_X;
        blank  = 1'b0;
        case (idx)
            2'd1: begin
                digit  = d1_q;
                char_x = X_TENS;
                blank  = (d2_q == 4'd0) && (d1_q == 4'd0);
            end
            2'd2: begin
                digit  = d0_q;
                char_x = X_UNITS;
            end
            default: blank = (d2_q == 4'd0);
        endcase
    end

    assign char_y    = BASE_Y;
    assign busy      = (state_q != IDLE);
    assign sat       = sat_q;
    assign sy_unused = ^sy;

endmodule
